// File: rtl/rvfi_pair_pkg.sv
// Shared types for the Left/Right RVFI retirement pair checker:
// the retirement record, the checker state encoding and the masked comparison.
package rvfi_pair_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
    } rvfi_rec_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MISMATCH = 2'd1,
        OVERFLOW = 2'd2,
        TIMEOUT  = 2'd3
    } chk_state_e;

    // Writes to x0 carry no architectural meaning, so their data is ignored.
    function automatic logic rec_eq(input rvfi_rec_t a, input rvfi_rec_t b);
        logic [31:0] wdata_a;
        logic [31:0] wdata_b;
        wdata_a = (a.rd_addr == 5'd0) ? 32'd0 : a.rd_wdata;
        wdata_b = (b.rd_addr == 5'd0) ? 32'd0 : b.rd_wdata;
        return (a.insn == b.insn) && (a.pc == b.pc) && (a.rd_addr == b.rd_addr) &&
               (wdata_a == wdata_b) && (a.trap == b.trap);
    endfunction

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Per-side retirement buffer. Push and pop may coincide at any fill level;
// a push into a full buffer without a pop is dropped.
module rvfi_rec_fifo
    import rvfi_pair_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push,
    input  rvfi_rec_t rec_in,
    input  logic      pop,
    output rvfi_rec_t head,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    rvfi_rec_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // The extra MSB on each pointer separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= rec_in;
    end

endmodule

// File: rtl/rvfi_pair_checker.sv
// Consumes the Left and Right RVFI retirement streams, buffers the stutter between
// them and compares retirements pairwise in program order, keeping a sticky verdict.
module rvfi_pair_checker
    import rvfi_pair_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        left_valid_i,
    input  logic [31:0] left_insn_i,
    input  logic [31:0] left_pc_i,
    input  logic [4:0]  left_rd_addr_i,
    input  logic [31:0] left_rd_wdata_i,
    input  logic        left_trap_i,
    input  logic        right_valid_i,
    input  logic [31:0] right_insn_i,
    input  logic [31:0] right_pc_i,
    input  logic [4:0]  right_rd_addr_i,
    input  logic [31:0] right_rd_wdata_i,
    input  logic        right_trap_i,
    output logic        equiv_o,
    output logic        mismatch_o,
    output logic        overflow_o,
    output logic        timeout_o,
    output logic [31:0] retired_cnt_o
);

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_MAX);

    rvfi_rec_t     left_rec;
    rvfi_rec_t     right_rec;
    rvfi_rec_t     left_head;
    rvfi_rec_t     right_head;
    logic          left_empty;
    logic          left_full;
    logic          right_empty;
    logic          right_full;
    logic          pop;
    logic          pair_eq;
    logic          ev_mismatch;
    logic          ev_overflow;
    logic          ev_timeout;
    logic [SW-1:0] stall_cnt;
    chk_state_e    state;

    assign left_rec  = '{insn: left_insn_i, pc: left_pc_i, rd_addr: left_rd_addr_i,
                         rd_wdata: left_rd_wdata_i, trap: left_trap_i};
    assign right_rec = '{insn: right_insn_i, pc: right_pc_i, rd_addr: right_rd_addr_i,
                         rd_wdata: right_rd_wdata_i, trap: right_trap_i};

    rvfi_rec_fifo #(.DEPTH(DEPTH)) u_left_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (left_valid_i),
        .rec_in (left_rec),
        .pop    (pop),
        .head   (left_head),
        .empty  (left_empty),
        .full   (left_full)
    );

    rvfi_rec_fifo #(.DEPTH(DEPTH)) u_right_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (right_valid_i),
        .rec_in (right_rec),
        .pop    (pop),
        .head   (right_head),
        .empty  (right_empty),
        .full   (right_full)
    );

    // A pair is consumed whenever both sides have a retirement waiting.
    assign pop         = !left_empty && !right_empty;
    assign pair_eq     = rec_eq(left_head, right_head);
    assign ev_mismatch = pop && !pair_eq;
    assign ev_overflow = (left_valid_i && left_full && !pop) ||
                         (right_valid_i && right_full && !pop);
    assign ev_timeout  = (stall_cnt == STALL_LIMIT);

    // Only one side can be non-empty here when no pop happens, so this counts lead cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (pop || (left_empty && right_empty)) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_LIMIT) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= RUN;
            equiv_o       <= 1'b1;
            mismatch_o    <= 1'b0;
            overflow_o    <= 1'b0;
            timeout_o     <= 1'b0;
            retired_cnt_o <= '0;
        end else if (state == RUN) begin
            if (pop && pair_eq && (retired_cnt_o != 32'hFFFF_FFFF))
                retired_cnt_o <= retired_cnt_o + 32'd1;
            if (ev_mismatch) begin
                state      <= MISMATCH;
                equiv_o    <= 1'b0;
                mismatch_o <= 1'b1;
            end else if (ev_overflow) begin
                state      <= OVERFLOW;
                equiv_o    <= 1'b0;
                overflow_o <= 1'b1;
            end else if (ev_timeout) begin
                state      <= TIMEOUT;
                equiv_o    <= 1'b0;
                timeout_o  <= 1'b1;
            end
        end
    end

endmodule
